fifo_wr_arb: RTL and testbench
==============================

// Module: fifo_wr_arb
// PURPOSE
//  Packet-level round-robin arbiter sharing the single write port of asynch_fifo among NREQ requesters.
//  - Holds the grant from a packet's first beat through its eop beat, so packets never interleave in the FIFO.
//  - Throttles writes on wrfull and enforces a maximum packet length.
//  - Sits in the wrclk domain, directly in front of the FIFO write side.
// PARAMETERS
//  NREQ    4    number of requesters (2..8)
//  WIDTH   8    data width, equal to the FIFO WIDTH
//  PTR     4    FIFO pointer width; wrusedw is PTR+1 bits
//  MAXLEN  64   maximum beats per packet before forced release
// PORTS
//  wrclk       in   1            write-domain clock, rising edge
//  reset       in   1            asynchronous, active-high reset
//  req         in   NREQ         requester i has a beat valid
//  req_data    in   NREQ*WIDTH   beat data; requester i occupies bits [i*WIDTH +: WIDTH]
//  req_eop     in   NREQ         beat is the last of its packet
//  gnt         out  NREQ         registered one-hot grant
//  ack         out  NREQ         beat accepted this cycle (combinational)
//  wren        out  1            FIFO write enable (combinational)
//  datain      out  WIDTH        FIFO write data (combinational mux)
//  wrfull      in   1            FIFO full
//  wrusedw     in   PTR+1        FIFO occupancy; reported only, not used for gating
//  busy        out  1            a packet is in progress (registered)
//  len_err     out  1            one-cycle pulse when MAXLEN is exceeded (registered)
// BEHAVIOUR
//  Reset values: state=IDLE, gnt=0, busy=0, len_err=0, last=NREQ-1 (so req[0] wins first), beat_cnt=0.
//  States:
//   - IDLE:
//     - if |req: pick the first set req scanning from last+1 modulo NREQ.
//     - Set gnt onehot and busy=1; go to XFER. Grant takes 1 cycle from req to gnt.
//   - XFER:
//     - ack[g] = wren = gnt[g] & req[g] & !wrfull; datain = req_data[g].
//     - On each ack: beat_cnt += 1.
//     - eop accepted (ack & req_eop[g]): gnt=0, busy=0, last=g, beat_cnt=0; go to IDLE.
//     - Accepted beat with beat_cnt==MAXLEN-1 and no eop: len_err pulse, release as for eop, go to IDLE.
//       The requester's remaining beats re-arbitrate as a new packet.
//  Boundary conditions:
//   - No grant is issued in the same cycle the previous packet ends (1 idle bubble).
//     Peak throughput is (L)/(L+1) for packet length L.
//   - wrfull high: wren=0, no ack, state and beat_cnt hold. Writes resume in the cycle wrfull drops.
//   - The granted requester deasserts req mid-packet: grant holds, no timeout.
//   - Single-beat packet (req & eop on the first beat): written, then release.
//   - Non-granted req bits are ignored in XFER. ack is never asserted to a non-granted requester.
//   - wren is never asserted while wrfull=1 or gnt==0.
//   - Reset mid-packet: immediate return to IDLE and reset values. A partial packet may remain in the FIFO.
//   - beat_cnt width: $clog2(MAXLEN)+1; it never wraps, because release occurs at MAXLEN.
// STRUCTURE
//  Shared package/header lewiz_fifo_pkg:
//   - state localparams ARB_IDLE=1'b0, ARB_XFER=1'b1
//   - clog2 function
//   - WIDTH/PTR defaults shared with asynch_fifo
//  Sub-module rr_pick:
//   - combinational rotate-priority encoder
//   - inputs req and last; outputs onehot and index
//   - used once, in IDLE
//  Top: state register, grant/last/beat_cnt registers, data mux, ack/wren logic.
// TESTING
//  1. req=4'b0001, 3-beat packet 0xA1,0xA2,0xA3 (eop on 3rd), wrfull=0
//     -> gnt=0001 one cycle after req; wren high 3 cycles; FIFO holds A1,A2,A3; busy drops after eop.
//  2. req=4'b1111 continuously, each packet 2 beats
//     -> grant order 0,1,2,3,0; one-cycle bubble between packets; no interleaved data.
//  3. wrfull forced high during beat 2 of 4 for 5 cycles
//     -> wren=0 and ack=0 for those 5 cycles; beat 2 is written in the first cycle after wrfull drops; 4 beats total.
//  4. MAXLEN=4, requester 2 sends 6 beats with no eop
//     -> len_err pulse on the 4th ack; gnt drops; requester 2 is re-granted; beats 5-6 land afterwards.
//  5. reset asserted during beat 2 of 3
//     -> gnt=0, wren=0, busy=0 in the same cycle (async); after release, req[0] wins first arbitration.
//  6. req=4'b0100 single beat with eop, then req=4'b0110
//     -> requester 2 written once; next grant goes to requester 1 (no starvation); ack is one-hot per cycle.

Source files
------------

// File: rtl/lewiz_fifo_pkg.sv
// Shared definitions for the asynch_fifo write side: arbiter state encoding,
// FIFO geometry defaults and a constant ceil(log2) helper.
package lewiz_fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_PTR   = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_XFER = 1'b1
  } arb_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_if.sv
// Requester/FIFO write-side bundle around fifo_wr_arb; master is the arbiter,
// slave is the environment (requesters plus FIFO status).
interface fifo_wr_arb_if
  import lewiz_fifo_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = FIFO_WIDTH,
  parameter int PTR   = FIFO_PTR
);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_eop;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic                  wren;
  logic [WIDTH-1:0]      datain;
  logic                  wrfull;
  logic [PTR:0]          wrusedw;
  logic                  busy;
  logic                  len_err;

  modport master (
    input  req, req_data, req_eop, wrfull, wrusedw,
    output gnt, ack, wren, datain, busy, len_err
  );

  modport slave (
    output req, req_data, req_eop, wrfull, wrusedw,
    input  gnt, ack, wren, datain, busy, len_err
  );

endinterface

// File: rtl/fifo_wr_arb_rr_pick.sv
// Rotating-priority encoder: first set req scanning upward from last+1 (mod NREQ).
// Purely combinational; no backpressure.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   index,
  output logic            vld
);

  always_comb begin
    logic [IW-1:0] p;
    onehot = '0;
    index  = '0;
    vld    = 1'b0;
    p      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      p = IW'((int'(last) + k) % NREQ);
      if (!vld && req[p]) begin
        vld       = 1'b1;
        onehot[p] = 1'b1;
        index     = p;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Packet-level round-robin arbiter for the asynch_fifo write port; grant lands one
// cycle after req, beats pass through combinationally, wrfull stalls the granted packet.
module fifo_wr_arb
  import lewiz_fifo_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int PTR    = FIFO_PTR,
  parameter int MAXLEN = 64
) (
  input  logic          wrclk,
  input  logic          reset,
  fifo_wr_arb_if.master arb
);

  localparam int IW = clog2(NREQ);
  localparam int CW = clog2(MAXLEN) + 1;

  arb_state_t       state;
  logic [NREQ-1:0]  gnt_q;
  logic [IW-1:0]    gidx;
  logic [IW-1:0]    last;
  logic [CW-1:0]    beat_cnt;
  logic             busy_q;
  logic             len_err_q;

  logic [NREQ-1:0]  pick_oh;
  logic [IW-1:0]    pick_idx;
  logic             pick_vld;
  logic [NREQ-1:0]  ack_c;
  logic             beat_acc;
  logic             acc_eop;
  logic             cnt_max;
  logic [WIDTH-1:0] dat_mux;
  logic             unused_wrusedw;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req    (arb.req),
    .last   (last),
    .onehot (pick_oh),
    .index  (pick_idx),
    .vld    (pick_vld)
  );

  // gnt_q is zero outside XFER, so this also keeps wren low while idle.
  assign ack_c    = gnt_q & arb.req & {NREQ{~arb.wrfull}};
  assign beat_acc = |ack_c;
  assign acc_eop  = |(ack_c & arb.req_eop);
  assign cnt_max  = (beat_cnt == CW'(MAXLEN - 1));

  always_comb begin
    dat_mux = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == IW'(i)) dat_mux = arb.req_data[i*WIDTH +: WIDTH];
    end
  end

  assign arb.ack     = ack_c;
  assign arb.wren    = beat_acc;
  assign arb.datain  = dat_mux;
  assign arb.gnt     = gnt_q;
  assign arb.busy    = busy_q;
  assign arb.len_err = len_err_q;

  // Occupancy is carried alongside for observers only; gating uses wrfull.
  assign unused_wrusedw = ^arb.wrusedw;

  always_ff @(posedge wrclk or posedge reset) begin
    if (reset) begin
      state     <= ARB_IDLE;
      gnt_q     <= '0;
      gidx      <= '0;
      last      <= IW'(NREQ - 1);
      beat_cnt  <= '0;
      busy_q    <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            gnt_q  <= pick_oh;
            gidx   <= pick_idx;
            busy_q <= 1'b1;
            state  <= ARB_XFER;
          end
        end
        ARB_XFER: begin
          if (beat_acc) begin
            // An over-long packet is cut here; its tail re-arbitrates as a new packet.
            if (acc_eop || cnt_max) begin
              gnt_q     <= '0;
              busy_q    <= 1'b0;
              last      <= gidx;
              beat_cnt  <= '0;
              len_err_q <= ~acc_eop;
              state     <= ARB_IDLE;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb (MAXLEN=4) with a write-side FIFO capture queue
// and a per-cycle monitor on ack/wren legality.
module tb_fifo_wr_arb;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 8;
  localparam int PTR    = 4;
  localparam int MAXLEN = 4;

  logic wrclk = 1'b0;
  logic reset = 1'b1;

  always #5 wrclk = ~wrclk;

  fifo_wr_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH), .PTR(PTR)) bus ();

  fifo_wr_arb #(
    .NREQ   (NREQ),
    .WIDTH  (WIDTH),
    .PTR    (PTR),
    .MAXLEN (MAXLEN)
  ) dut (
    .wrclk (wrclk),
    .reset (reset),
    .arb   (bus.master)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] fifo_q[$];

  // Grant/data per cycle for 4 requesters x 2-beat packets, all requesting.
  int exp_gnt [15] = '{0, 1, 1, 0, 2, 2, 0, 4, 4, 0, 8, 8, 0, 1, 1};
  int exp_dat [15] = '{0, 'h00, 'h01, 0, 'h10, 'h11, 0, 'h20, 'h21, 0, 'h30, 'h31, 0, 'h02, 'h03};
  int exp_fq2 [10] = '{'h00, 'h01, 'h10, 'h11, 'h20, 'h21, 'h30, 'h31, 'h02, 'h03};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_fifo(input string tag, input int idx, input logic [31:0] exp);
    logic [31:0] got;
    got = (idx < fifo_q.size()) ? 32'(fifo_q[idx]) : 32'hDEAD;
    check_val(tag, got, exp);
  endtask

  task automatic tick();
    @(posedge wrclk);
    #1;
  endtask

  task automatic idle_in();
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_eop  = '0;
  endtask

  task automatic put(input int i, input logic [7:0] d, input logic e);
    bus.req[i]                   = 1'b1;
    bus.req_data[i*WIDTH +: WIDTH] = d;
    bus.req_eop[i]               = e;
  endtask

  task automatic drop(input int i);
    bus.req[i]     = 1'b0;
    bus.req_eop[i] = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    idle_in();
    bus.wrfull = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // FIFO write-side model: captures every written beat (not cleared by arbiter reset).
  always @(posedge wrclk) begin
    if (bus.wren) fifo_q.push_back(bus.datain);
  end

  always @(negedge wrclk) begin
    if (!reset) begin
      check_val("mon_wren_gate", 32'(bus.wren & (bus.wrfull | ~(|bus.gnt))), 0);
      check_val("mon_ack_1hot", 32'($onehot0(bus.ack)), 1);
      check_val("mon_ack_in_gnt", 32'(bus.ack & ~bus.gnt), 0);
      check_val("mon_wren_ack", 32'(bus.wren), 32'(|bus.ack));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int beats [NREQ];
    logic [NREQ-1:0] acked;

    idle_in();
    bus.wrfull  = 1'b0;
    bus.wrusedw = '0;

    // Reset values, with a request already pending
    put(0, 8'hA1, 1'b0);
    tick();
    #1;
    check_val("rst_gnt", 32'(bus.gnt), 0);
    check_val("rst_busy", 32'(bus.busy), 0);
    check_val("rst_len_err", 32'(bus.len_err), 0);
    check_val("rst_wren", 32'(bus.wren), 0);

    // 1: single 3-beat packet from requester 0
    do_reset();
    base = fifo_q.size();
    put(0, 8'hA1, 1'b0);
    #1;
    check_val("t1_gnt_pre", 32'(bus.gnt), 0);
    check_val("t1_wren_pre", 32'(bus.wren), 0);
    tick();
    #1;
    check_val("t1_gnt", 32'(bus.gnt), 32'h1);
    check_val("t1_busy", 32'(bus.busy), 1);
    check_val("t1_ack1", 32'(bus.ack), 32'h1);
    check_val("t1_dat1", 32'(bus.datain), 32'hA1);
    tick();
    put(0, 8'hA2, 1'b0);
    #1;
    check_val("t1_wren2", 32'(bus.wren), 1);
    check_val("t1_dat2", 32'(bus.datain), 32'hA2);
    tick();
    put(0, 8'hA3, 1'b1);
    #1;
    check_val("t1_wren3", 32'(bus.wren), 1);
    check_val("t1_dat3", 32'(bus.datain), 32'hA3);
    tick();
    idle_in();
    #1;
    check_val("t1_gnt_end", 32'(bus.gnt), 0);
    check_val("t1_busy_end", 32'(bus.busy), 0);
    check_val("t1_fifo_n", 32'(fifo_q.size() - base), 3);
    check_fifo("t1_fifo0", base + 0, 32'hA1);
    check_fifo("t1_fifo1", base + 1, 32'hA2);
    check_fifo("t1_fifo2", base + 2, 32'hA3);

    // 2: all four requesting, 2-beat packets, round-robin with bubble
    do_reset();
    base = fifo_q.size();
    for (int i = 0; i < NREQ; i++) beats[i] = 0;
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < NREQ; i++) put(i, 8'(i * 16 + beats[i]), (beats[i] % 2) == 1);
      #1;
      check_val($sformatf("t2_gnt_c%0d", c), 32'(bus.gnt), 32'(exp_gnt[c]));
      check_val($sformatf("t2_wren_c%0d", c), 32'(bus.wren), 32'(exp_gnt[c] != 0));
      if (exp_gnt[c] != 0)
        check_val($sformatf("t2_dat_c%0d", c), 32'(bus.datain), 32'(exp_dat[c]));
      acked = bus.ack;
      tick();
      for (int i = 0; i < NREQ; i++) if (acked[i]) beats[i]++;
    end
    idle_in();
    #1;
    check_val("t2_fifo_n", 32'(fifo_q.size() - base), 10);
    for (int k = 0; k < 10; k++) check_fifo($sformatf("t2_fifo%0d", k), base + k, 32'(exp_fq2[k]));

    // 3: wrfull for 5 cycles during beat 2 of 4
    do_reset();
    base = fifo_q.size();
    put(1, 8'hB1, 1'b0);
    tick();
    #1;
    check_val("t3_ack1", 32'(bus.ack), 32'h2);
    check_val("t3_dat1", 32'(bus.datain), 32'hB1);
    tick();
    for (int k = 0; k < 5; k++) begin
      put(1, 8'hB2, 1'b0);
      bus.wrfull = 1'b1;
      #1;
      check_val($sformatf("t3_full_wren%0d", k), 32'(bus.wren), 0);
      check_val($sformatf("t3_full_ack%0d", k), 32'(bus.ack), 0);
      check_val($sformatf("t3_full_gnt%0d", k), 32'(bus.gnt), 32'h2);
      tick();
    end
    bus.wrfull = 1'b0;
    #1;
    check_val("t3_resume_wren", 32'(bus.wren), 1);
    check_val("t3_resume_dat", 32'(bus.datain), 32'hB2);
    tick();
    put(1, 8'hB3, 1'b0);
    #1;
    check_val("t3_dat3", 32'(bus.datain), 32'hB3);
    tick();
    put(1, 8'hB4, 1'b1);
    #1;
    check_val("t3_dat4", 32'(bus.datain), 32'hB4);
    check_val("t3_len_err4", 32'(bus.len_err), 0);
    tick();
    idle_in();
    #1;
    check_val("t3_gnt_end", 32'(bus.gnt), 0);
    check_val("t3_len_err_end", 32'(bus.len_err), 0);
    check_val("t3_fifo_n", 32'(fifo_q.size() - base), 4);
    check_fifo("t3_fifo1", base + 1, 32'hB2);
    check_fifo("t3_fifo3", base + 3, 32'hB4);

    // 4: requester 2 exceeds MAXLEN=4 with no eop
    do_reset();
    base = fifo_q.size();
    put(2, 8'hC1, 1'b0);
    tick();
    for (int n = 1; n <= 4; n++) begin
      put(2, 8'(8'hC0 + n), 1'b0);
      #1;
      check_val($sformatf("t4_ack%0d", n), 32'(bus.ack), 32'h4);
      check_val($sformatf("t4_dat%0d", n), 32'(bus.datain), 32'(8'hC0 + n));
      check_val($sformatf("t4_noerr%0d", n), 32'(bus.len_err), 0);
      tick();
    end
    put(2, 8'hC5, 1'b0);
    #1;
    check_val("t4_len_err", 32'(bus.len_err), 1);
    check_val("t4_gnt_rel", 32'(bus.gnt), 0);
    check_val("t4_busy_rel", 32'(bus.busy), 0);
    tick();
    #1;
    check_val("t4_len_err_clr", 32'(bus.len_err), 0);
    check_val("t4_regnt", 32'(bus.gnt), 32'h4);
    check_val("t4_dat5", 32'(bus.datain), 32'hC5);
    tick();
    put(2, 8'hC6, 1'b0);
    #1;
    check_val("t4_dat6", 32'(bus.datain), 32'hC6);
    tick();
    drop(2);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_val($sformatf("t4_hold_gnt%0d", k), 32'(bus.gnt), 32'h4);
      check_val($sformatf("t4_hold_busy%0d", k), 32'(bus.busy), 1);
      tick();
    end
    check_val("t4_fifo_n", 32'(fifo_q.size() - base), 6);
    check_fifo("t4_fifo4", base + 4, 32'hC5);
    check_fifo("t4_fifo5", base + 5, 32'hC6);

    // 5: async reset during beat 2 of 3; afterwards req[0] wins
    do_reset();
    base = fifo_q.size();
    put(1, 8'hD0, 1'b1);
    tick();
    #1;
    check_val("t5_ack_r1", 32'(bus.ack), 32'h2);
    tick();
    drop(1);
    put(0, 8'hD1, 1'b0);
    #1;
    check_val("t5_bubble", 32'(bus.gnt), 0);
    tick();
    #1;
    check_val("t5_gnt0", 32'(bus.gnt), 32'h1);
    check_val("t5_dat1", 32'(bus.datain), 32'hD1);
    tick();
    put(0, 8'hD2, 1'b0);
    #1;
    check_val("t5_wren2", 32'(bus.wren), 1);
    #2;
    reset = 1'b1;
    #1;
    check_val("t5_rst_gnt", 32'(bus.gnt), 0);
    check_val("t5_rst_wren", 32'(bus.wren), 0);
    check_val("t5_rst_busy", 32'(bus.busy), 0);
    tick();
    reset = 1'b0;
    idle_in();
    for (int i = 0; i < NREQ; i++) put(i, 8'(8'hE0 + i), 1'b1);
    tick();
    #1;
    check_val("t5_first_gnt", 32'(bus.gnt), 32'h1);
    check_val("t5_first_dat", 32'(bus.datain), 32'hE0);
    tick();
    idle_in();
    #1;
    check_val("t5_fifo_n", 32'(fifo_q.size() - base), 3);
    check_fifo("t5_fifo1", base + 1, 32'hD1);
    check_fifo("t5_fifo2", base + 2, 32'hE0);

    // 6: single-beat packet from 2, then 1 and 2 compete
    do_reset();
    base = fifo_q.size();
    put(2, 8'hF0, 1'b1);
    tick();
    #1;
    check_val("t6_gnt2", 32'(bus.gnt), 32'h4);
    check_val("t6_ack2", 32'(bus.ack), 32'h4);
    check_val("t6_dat2", 32'(bus.datain), 32'hF0);
    tick();
    put(1, 8'hF1, 1'b1);
    put(2, 8'hF2, 1'b1);
    #1;
    check_val("t6_bubble", 32'(bus.gnt), 0);
    check_val("t6_bubble_ack", 32'(bus.ack), 0);
    tick();
    #1;
    check_val("t6_gnt1", 32'(bus.gnt), 32'h2);
    check_val("t6_ack1", 32'(bus.ack), 32'h2);
    check_val("t6_dat1", 32'(bus.datain), 32'hF1);
    tick();
    drop(1);
    #1;
    check_val("t6_bubble2", 32'(bus.gnt), 0);
    tick();
    #1;
    check_val("t6_gnt2b", 32'(bus.gnt), 32'h4);
    check_val("t6_dat2b", 32'(bus.datain), 32'hF2);
    tick();
    idle_in();
    #1;
    check_val("t6_fifo_n", 32'(fifo_q.size() - base), 3);
    check_fifo("t6_fifo0", base + 0, 32'hF0);
    check_fifo("t6_fifo1", base + 1, 32'hF1);
    check_fifo("t6_fifo2", base + 2, 32'hF2);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
